// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg: shared ALU op codes, M-extension iteration count and op decode.
package alu_muldiv_pkg;
    localparam int ITER = 32;
    localparam logic [4:0] OPNULL   = 5'h00;
    localparam logic [4:0] OPADD    = 5'h01;
    localparam logic [4:0] OPSUB    = 5'h02;
    localparam logic [4:0] OPAND    = 5'h03;
    localparam logic [4:0] OPOR     = 5'h04;
    localparam logic [4:0] OPXOR    = 5'h05;
    localparam logic [4:0] OPMUL    = 5'h10;
    localparam logic [4:0] OPMULH   = 5'h11;
    localparam logic [4:0] OPMULHSU = 5'h12;
    localparam logic [4:0] OPMULHU  = 5'h13;
    localparam logic [4:0] OPDIV    = 5'h14;
    localparam logic [4:0] OPDIVU   = 5'h15;
    localparam logic [4:0] OPREM    = 5'h16;
    localparam logic [4:0] OPREMU   = 5'h17;
    typedef struct packed {
        logic md;
        logic div;
        logic sa;
        logic sb;
    } md_dec_t;
    function automatic md_dec_t md_decode(logic [4:0] op);
        md_dec_t d;
        d.md  = op inside {OPMUL, OPMULH, OPMULHSU, OPMULHU, OPDIV, OPDIVU, OPREM, OPREMU};
        d.div = op inside {OPDIV, OPDIVU, OPREM, OPREMU};
        d.sa  = op inside {OPMUL, OPMULH, OPMULHSU, OPDIV, OPREM};
        d.sb  = op inside {OPMUL, OPMULH, OPDIV, OPREM};
        return d;
    endfunction
endpackage

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: start/busy/done handshake and operand buses of the mul/div unit.
interface alu_muldiv_if;
    logic        iStart;
    logic [4:0]  iControl;
    logic [31:0] iA;
    logic [31:0] iB;
    logic [31:0] oResult;
    logic        oBusy;
    logic        oDone;
    modport master (output iStart, iControl, iA, iB, input oResult, oBusy, oDone);
    modport slave  (input iStart, iControl, iA, iB, output oResult, oBusy, oDone);
endinterface

// File: rtl/alu_muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring shift-subtract divide.
module muldiv_step (
    input  logic        div_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] m_i,
    output logic [63:0] acc_o
);
    logic [32:0] sum;
    logic [32:0] part;
    logic [33:0] diff;
    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        sum   = {1'b0, acc_i[63:32]} + {1'b0, acc_i[0] ? m_i : 32'd0};
        part  = acc_i[63:31];
        diff  = {1'b0, part} - {2'b00, m_i};
        acc_o = div_i ? {diff[33] ? part[31:0] : diff[31:0], acc_i[30:0], ~diff[33]}
                      : {sum, acc_i[31:1]};
    end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide, 32 cycles from accept to a one-cycle done pulse.
module alu_muldiv
    import alu_muldiv_pkg::*;
(
    input  logic iCLK,
    input  logic iRST,
    alu_muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state_q;
    logic [4:0]  op_q;
    logic [5:0]  cnt_q;
    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic [31:0] m_q;
    logic        div_q;
    logic        neg_q;
    logic        sa_q;
    logic        dz_q;
    logic [31:0] result_q;
    logic        busy_q;
    logic        done_q;
    md_dec_t     dec;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res;

    muldiv_step u_step (.div_i(div_q), .acc_i(acc_q), .m_i(m_q), .acc_o(acc_d));

    always_comb begin
        dec   = md_decode(bus.iControl);
        neg_a = dec.sa && bus.iA[31];
        neg_b = dec.sb && bus.iB[31];
        mag_a = neg_a ? -bus.iA : bus.iA;
        mag_b = neg_b ? -bus.iB : bus.iB;
        prod  = neg_q ? -acc_d : acc_d;
        quo   = dz_q ? 32'hFFFF_FFFF : (neg_q ? -acc_d[31:0] : acc_d[31:0]);
        rem   = sa_q ? -acc_d[63:32] : acc_d[63:32];
        res   = (op_q == OPMUL) ? prod[31:0]
              : (op_q == OPDIV || op_q == OPDIVU) ? quo
              : (op_q == OPREM || op_q == OPREMU) ? rem
              : prod[63:32];
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= IDLE;
            op_q     <= OPNULL;
            cnt_q    <= '0;
            acc_q    <= '0;
            m_q      <= '0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.iStart && dec.md) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        op_q    <= bus.iControl;
                        cnt_q   <= '0;
                        div_q   <= dec.div;
                        acc_q   <= {32'd0, dec.div ? mag_a : mag_b};
                        m_q     <= dec.div ? mag_b : mag_a;
                        neg_q   <= neg_a ^ neg_b;
                        sa_q    <= neg_a;
                        dz_q    <= dec.div && (bus.iB == 32'd0);
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(ITER - 1)) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= res;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.oResult = result_q;
    assign bus.oBusy   = busy_q;
    assign bus.oDone   = done_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: vector table plus scoreboard queue, with handshake and reset corner sequences.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    alu_muldiv_if bus();
    alu_muldiv dut (.iCLK(clk), .iRST(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[14];
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OPMUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            OPMULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            OPMULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
            OPMULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            OPDIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            OPREM:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            OPDIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.iStart = 1'b1;
        bus.iControl = op;
        bus.iA = a;
        bus.iB = b;
        @(posedge clk);
        #1;
        bus.iStart = 1'b0;
        bus.iControl = OPADD;
        bus.iA = $urandom;
        bus.iB = $urandom;
    endtask

    // Called #1 after the accept edge; waits for done, checks latency, busy, pulse width and result.
    task automatic wait_done(input string name, input int hit_cycle, input logic [4:0] hit_op);
        int lat = 0;
        int busy_bad = 0;
        logic [31:0] req;
        if (bus.oBusy !== 1'b1) busy_bad++;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.oDone === 1'b1) begin
                lat = k;
                if (bus.oBusy !== 1'b0) busy_bad++;
            end else if (bus.oBusy !== 1'b1) busy_bad++;
            if (k == hit_cycle) begin
                bus.iStart = 1'b1;
                bus.iControl = hit_op;
                bus.iA = 32'd5;
                bus.iB = 32'd6;
                @(posedge clk);
                #1;
                bus.iStart = 1'b0;
                k++;
                if (bus.oBusy !== 1'b1) busy_bad++;
            end
        end
        chk({name, " latency"}, 32'(lat), 32'd32);
        chk({name, " busy"}, 32'(busy_bad), 32'd0);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got result %h, expected nothing pending", name, bus.oResult);
        end else begin
            req = exp_q.pop_front();
            chk({name, " result"}, bus.oResult, req);
        end
        @(posedge clk);
        #1;
        chk({name, " pulse"}, {31'd0, bus.oDone}, 32'd0);
    endtask

    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] req);
        start_op(op, a, b);
        exp_q.push_back(req);
        wait_done(name, 0, OPNULL);
    endtask

    initial begin
        int seen;
        logic [4:0] op;
        logic [31:0] a, b;
        bus.iStart = 1'b0;
        bus.iControl = OPNULL;
        bus.iA = '0;
        bus.iB = '0;
        vecs[0]  = '{OPMUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{OPMULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{OPMULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{OPMULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{OPDIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{OPREM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{OPDIVU,   32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC};
        vecs[7]  = '{OPDIV,    32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[8]  = '{OPREMU,   32'd5,          32'd0,         32'd5};
        vecs[9]  = '{OPDIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[10] = '{OPREM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[11] = '{OPDIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[12] = '{OPREM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB};
        vecs[13] = '{OPDIV,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF};
        #1;
        chk("reset busy", {31'd0, bus.oBusy}, 32'd0);
        chk("reset done", {31'd0, bus.oDone}, 32'd0);
        chk("reset result", bus.oResult, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        for (int i = 0; i < 16; i++) begin
            op = OPMUL + 5'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 5 == 4) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            run_op($sformatf("rand%0d", i), op, a, b, model(op, a, b));
        end
        start_op(OPMUL, 32'd3, 32'd4);
        exp_q.push_back(32'd12);
        wait_done("restart_ignored", 10, OPMUL);
        start_op(OPADD, 32'd1, 32'd2);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.oBusy !== 1'b0 || bus.oDone !== 1'b0) seen++;
            @(posedge clk);
            #1;
        end
        chk("opadd ignored", 32'(seen), 32'd0);
        start_op(OPDIV, 32'd1000, 32'd3);
        for (int k = 0; k < 15; k++) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort busy", {31'd0, bus.oBusy}, 32'd0);
        chk("abort done", {31'd0, bus.oDone}, 32'd0);
        chk("abort result", bus.oResult, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.oDone !== 1'b0 || bus.oBusy !== 1'b0) seen++;
        end
        chk("abort no done", 32'(seen), 32'd0);
        run_op("divu_after_reset", OPDIVU, 32'd100, 32'd7, 32'd14);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
